phy_mgmt_controller: RTL

PHY_MGMT_CONTROLLER -- requirements
Module: phy_mgmt_controller

---
 rtl/phy_mgmt_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/phy_mgmt_controller.sv
// PHY bring-up and MDIO management: hardware reset, settle wait, BMCR write, restart rewrites.
// Define PHY_LINK_POLL_EN to add periodic register 1 reads that drive link_up.
module phy_mgmt_controller #(
    parameter int unsigned CLK_DIV      = 25,
    parameter logic [4:0]  PHY_ADDR     = 5'd7,
    parameter int unsigned RESET_CYCLES = 20000,
    parameter int unsigned WAIT_CYCLES  = 200000,
    parameter logic [15:0] BMCR_VALUE   = 16'h1340
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       an_restart_config,
    input  logic       eth_mdio_i,
    output logic       eth_mdio_o,
    output logic       eth_mdio_t,
    output logic       eth_mdc,
    output logic       eth_reset_n,
    output logic       init_done,
    output logic       busy,
    output logic       link_up,
    output logic [2:0] debug_state
);
    typedef enum logic [2:0] {
        PHY_RST    = 3'd0,
        PHY_WAIT   = 3'd1,
        CFG_WR     = 3'd2,
        IDLE       = 3'd3,
        RESTART_WR = 3'd4
`ifdef PHY_LINK_POLL_EN
        ,POLL_RD   = 3'd5
`endif
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);

    state_t      state;
    logic [31:0] cnt;
    logic        restart_prev;
    logic        restart_rise;
    logic        pending;
    logic        poll_due;
    logic        launch;
    logic        launch_read;
    logic [63:0] launch_word;
    logic        frame_active;
    logic        frame_read;
    logic        frame_done;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_idx;
    logic [63:0] shreg;
`ifdef PHY_LINK_POLL_EN
    logic [15:0] rd_shift;
    logic        last_sample;
    logic [19:0] poll_cnt;
`endif

    assign restart_rise = an_restart_config & ~restart_prev;
    assign debug_state  = state;

    // A frame is launched only from PHY_WAIT expiry or from IDLE; restart beats poll.
    always_comb begin
        launch      = 1'b0;
        launch_read = 1'b0;
        case (state)
            PHY_WAIT: launch = (cnt == WAIT_LAST);
            IDLE: begin
                if (pending) begin
                    launch = 1'b1;
                end else if (poll_due) begin
                    launch      = 1'b1;
                    launch_read = 1'b1;
                end
            end
            default: ;
        endcase
        launch_word = {32'hFFFF_FFFF, 2'b01, (launch_read ? 2'b10 : 2'b01), PHY_ADDR,
                       (launch_read ? 5'd1 : 5'd0), 2'b10, (launch_read ? 16'hFFFF : BMCR_VALUE)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= PHY_RST;
            cnt          <= '0;
            eth_reset_n  <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b1;
            restart_prev <= 1'b0;
            pending      <= 1'b0;
        end else begin
            restart_prev <= an_restart_config;
            // A new edge in the launch cycle survives the clear and yields one more write.
            pending <= (pending & ~(launch && (state == IDLE) && !launch_read)) | restart_rise;
            case (state)
                PHY_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt         <= '0;
                        eth_reset_n <= 1'b1;
                        state       <= PHY_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PHY_WAIT: begin
                    if (launch) begin
                        cnt   <= '0;
                        state <= CFG_WR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CFG_WR: begin
                    if (frame_done) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (launch) begin
                        busy <= 1'b1;
`ifdef PHY_LINK_POLL_EN
                        state <= launch_read ? POLL_RD : RESTART_WR;
`else
                        state <= RESTART_WR;
`endif
                    end
                end
                default: begin
                    if (frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // MDIO frame engine: bits advance on MDC fall, read data is taken on MDC rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_active <= 1'b0;
            frame_read   <= 1'b0;
            frame_done   <= 1'b0;
            div_cnt      <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            eth_mdc      <= 1'b0;
            eth_mdio_o   <= 1'b1;
            eth_mdio_t   <= 1'b1;
`ifdef PHY_LINK_POLL_EN
            rd_shift     <= '0;
            last_sample  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef PHY_LINK_POLL_EN
            last_sample <= 1'b0;
`endif
            if (launch) begin
                frame_active <= 1'b1;
                frame_read   <= launch_read;
                div_cnt      <= '0;
                bit_idx      <= '0;
                eth_mdc      <= 1'b0;
                eth_mdio_o   <= launch_word[63];
                eth_mdio_t   <= 1'b0;
                shreg        <= {launch_word[62:0], 1'b0};
            end else if (frame_active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    eth_mdc <= ~eth_mdc;
                    if (!eth_mdc) begin
`ifdef PHY_LINK_POLL_EN
                        if (frame_read && (bit_idx >= 6'd48)) begin
                            rd_shift    <= {rd_shift[14:0], eth_mdio_i};
                            last_sample <= (bit_idx == 6'd63);
                        end
`endif
                    end else if (bit_idx == 6'd63) begin
                        frame_active <= 1'b0;
                        frame_done   <= 1'b1;
                        eth_mdio_o   <= 1'b1;
                        eth_mdio_t   <= 1'b1;
                    end else begin
                        bit_idx    <= bit_idx + 6'd1;
                        eth_mdio_o <= shreg[63];
                        shreg      <= {shreg[62:0], 1'b0};
                        if (frame_read && (bit_idx >= 6'd45)) begin
                            eth_mdio_t <= 1'b1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

`ifdef PHY_LINK_POLL_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
            poll_due <= 1'b0;
            link_up  <= 1'b0;
        end else begin
            if (init_done) begin
                poll_cnt <= poll_cnt + 20'd1;
            end
            if (launch && launch_read) begin
                poll_due <= 1'b0;
            end else if (init_done && (poll_cnt == 20'hF_FFFF)) begin
                poll_due <= 1'b1;
            end
            if (last_sample) begin
                link_up <= rd_shift[2];
            end
        end
    end
`else
    logic unused_mdio_in;
    assign unused_mdio_in = eth_mdio_i;
    assign poll_due       = 1'b0;
    assign link_up        = 1'b0;
`endif
endmodule
